// File: rtl/freq_gate_ctrl_if.sv
// rtl/freq_gate_ctrl_if.sv - control and result handshake bundle for the frequency gate sequencer
interface freq_gate_ctrl_if #(
    parameter int CNT_W = 24
);
    logic             start;
    logic             continuous;
    logic [1:0]       gate_sel;
    logic             busy;
    logic [CNT_W-1:0] result;
    logic             result_valid;
    logic             result_ack;
    logic             overflow;
    logic [1:0]       gate_used;

    // Controller / readout side
    modport master (
        output start, continuous, gate_sel, result_ack,
        input  busy, result, result_valid, overflow, gate_used
    );

    // Sequencer side
    modport slave (
        input  start, continuous, gate_sel, result_ack,
        output busy, result, result_valid, overflow, gate_used
    );
endinterface

// File: rtl/freq_gate_ctrl.sv
// rtl/freq_gate_ctrl.sv - gated edge-count measurement sequencer (optional FREQ_AUTORANGE_EN)
module freq_gate_ctrl #(
    parameter int CLK_HZ      = 50000000,
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic           sysclk,
    input  logic           rst_n,
    input  logic           sigin,
    freq_gate_ctrl_if.slave bus
);
    localparam int TMR_W = $clog2(CLK_HZ + 1);
    typedef logic [TMR_W-1:0] tmr_t;

    // Timer terminal values: the gate spans timer values 0 .. G-1
    localparam tmr_t G0_LAST = tmr_t'(CLK_HZ - 1);
    localparam tmr_t G1_LAST = tmr_t'(CLK_HZ / 10 - 1);
    localparam tmr_t G2_LAST = tmr_t'(CLK_HZ / 100 - 1);
    localparam tmr_t G3_LAST = tmr_t'(CLK_HZ / 1000 - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, GATE, LATCH, HOLD} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;
    logic                   rise;
    tmr_t                   tmr;
    tmr_t                   gate_last;
    logic [CNT_W-1:0]       cnt;
    logic                   sat;
    logic [1:0]             gsel_q;
    logic                   cont_q;
    logic                   range_up;
    logic [CNT_W-1:0]       result_q;
    logic                   valid_q;
    logic                   overflow_q;
    logic [1:0]             gate_used_q;

    // Bring sigin into the sysclk domain and keep one extra stage for edge detection
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], sigin};
            sync_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~sync_prev;

    // Last timer value of the gate selected at gate open
    always_comb begin
        gate_last = G0_LAST;
        case (gsel_q)
            2'b00:   gate_last = G0_LAST;
            2'b01:   gate_last = G1_LAST;
            2'b10:   gate_last = G2_LAST;
            default: gate_last = G3_LAST;
        endcase
    end

`ifdef FREQ_AUTORANGE_EN
    assign range_up = sat && (gsel_q != 2'b11);
`else
    assign range_up = 1'b0;
`endif

    // Measurement sequencer: open gate, count rises, latch result, hand off
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tmr         <= '0;
            cnt         <= '0;
            sat         <= 1'b0;
            gsel_q      <= 2'b00;
            cont_q      <= 1'b0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            gate_used_q <= 2'b00;
        end else begin
            // Acceptance clears valid anywhere; a LATCH below overrides it
            if (valid_q && bus.result_ack)
                valid_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        gsel_q <= bus.gate_sel;
                        cont_q <= bus.continuous;
                        cnt    <= '0;
                        sat    <= 1'b0;
                        tmr    <= '0;
                        state  <= GATE;
                    end
                end
                GATE: begin
                    if (rise) begin
                        if (cnt == CNT_MAX)
                            sat <= 1'b1;
                        else
                            cnt <= cnt + 1'b1;
                    end
                    if (tmr == gate_last)
                        state <= LATCH;
                    else
                        tmr <= tmr + 1'b1;
                end
                LATCH: begin
                    if (range_up) begin
                        // Too many edges for this gate: retry with the next shorter one
                        gsel_q <= gsel_q + 2'd1;
                        cnt    <= '0;
                        sat    <= 1'b0;
                        tmr    <= '0;
                        state  <= GATE;
                    end else begin
                        result_q    <= cnt;
                        overflow_q  <= sat;
                        gate_used_q <= gsel_q;
                        valid_q     <= 1'b1;
                        if (cont_q && bus.continuous) begin
                            gsel_q <= bus.gate_sel;
                            cnt    <= '0;
                            sat    <= 1'b0;
                            tmr    <= '0;
                            state  <= GATE;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.result_ack)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy         = (state == GATE) || (state == LATCH);
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.overflow     = overflow_q;
    assign bus.gate_used    = gate_used_q;
endmodule

// File: tb/tb_freq_gate_ctrl.sv
// tb/tb_freq_gate_ctrl.sv - directed self-checking bench for freq_gate_ctrl
module tb_freq_gate_ctrl;
    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;
    logic sig_a  = 1'b0;
    logic sig_b  = 1'b0;
    int   per_a  = 0;
    int   per_b  = 0;
    int   checks   = 0;
    int   failures = 0;
    int   n;

    always #5 sysclk = ~sysclk;

    freq_gate_ctrl_if #(.CNT_W(24)) bus_a ();
    freq_gate_ctrl_if #(.CNT_W(4))  bus_b ();

    freq_gate_ctrl #(.CLK_HZ(100000), .CNT_W(24), .SYNC_STAGES(2)) dut_a (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .sigin  (sig_a),
        .bus    (bus_a)
    );

    freq_gate_ctrl #(.CLK_HZ(100000), .CNT_W(4), .SYNC_STAGES(2)) dut_b (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .sigin  (sig_b),
        .bus    (bus_b)
    );

    // Square-wave generators; period 0 holds the line low
    initial begin
        int ph_a = 0;
        int ph_b = 0;
        forever begin
            @(negedge sysclk);
            if (per_a == 0) sig_a = 1'b0;
            else begin ph_a = (ph_a + 1) % per_a; sig_a = (ph_a < per_a / 2); end
            if (per_b == 0) sig_b = 1'b0;
            else begin ph_b = (ph_b + 1) % per_b; sig_b = (ph_b < per_b / 2); end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Count negedges with busy high, starting from the current one
    task automatic count_busy_a(output int cnt);
        cnt = 0;
        while (bus_a.busy && cnt < 5000) begin cnt++; @(negedge sysclk); end
    endtask

    task automatic count_busy_b(output int cnt);
        cnt = 0;
        while (bus_b.busy && cnt < 5000) begin cnt++; @(negedge sysclk); end
    endtask

    initial begin
        bus_a.start = 0; bus_a.continuous = 0; bus_a.gate_sel = 2'b11; bus_a.result_ack = 0;
        bus_b.start = 0; bus_b.continuous = 0; bus_b.gate_sel = 2'b10; bus_b.result_ack = 0;

        // Reset state
        repeat (3) @(negedge sysclk);
        check("rst_busy", 32'(bus_a.busy), 0);
        check("rst_valid", 32'(bus_a.result_valid), 0);
        check("rst_result", 32'(bus_a.result), 0);
        check("rst_ovf", 32'(bus_a.overflow), 0);
        check("rst_gate_used", 32'(bus_a.gate_used), 0);
        rst_n = 1'b1;
        @(negedge sysclk);

        // Single shot, period 10, G=100; extra start mid-gate must not restart the timer
        per_a = 10;
        repeat (5) @(negedge sysclk);
        bus_a.start = 1;
        @(negedge sysclk);
        bus_a.start = 0;
        n = 0;
        while (bus_a.busy && n < 5000) begin
            n++;
            bus_a.start = (n == 50);
            @(negedge sysclk);
        end
        bus_a.start = 0;
        check("a_busy_cycles", 32'(n), 101);
        check("a_valid", 32'(bus_a.result_valid), 1);
        check("a_result_range", 32'(bus_a.result >= 9 && bus_a.result <= 11), 1);
        check("a_gate_used", 32'(bus_a.gate_used), 3);
        check("a_ovf", 32'(bus_a.overflow), 0);

        // start in HOLD is ignored
        bus_a.gate_sel = 2'b00;
        bus_a.start = 1;
        @(negedge sysclk);
        bus_a.start = 0;
        @(negedge sysclk);
        check("hold_start_busy", 32'(bus_a.busy), 0);
        check("hold_start_valid", 32'(bus_a.result_valid), 1);
        check("hold_gate_used", 32'(bus_a.gate_used), 3);
        bus_a.result_ack = 1;
        @(negedge sysclk);
        bus_a.result_ack = 0;
        check("ack_clears_valid", 32'(bus_a.result_valid), 0);
        check("ack_idle_busy", 32'(bus_a.busy), 0);

        // sigin held low
        per_a = 0;
        bus_a.gate_sel = 2'b11;
        repeat (5) @(negedge sysclk);
        bus_a.start = 1;
        @(negedge sysclk);
        bus_a.start = 0;
        count_busy_a(n);
        check("z_busy_cycles", 32'(n), 101);
        check("z_result", 32'(bus_a.result), 0);
        check("z_valid", 32'(bus_a.result_valid), 1);
        bus_a.result_ack = 1;
        @(negedge sysclk);
        bus_a.result_ack = 0;
        check("z_ack_valid", 32'(bus_a.result_valid), 0);
        @(negedge sysclk);

        // Continuous: latches at P101, P202, P303 after start taken at P0
        per_a = 10;
        bus_a.continuous = 1;
        bus_a.start = 1;                       // N0
        @(negedge sysclk);
        bus_a.start = 0;                       // N1
        repeat (100) @(negedge sysclk);        // N101
        check("c_valid_before_1st", 32'(bus_a.result_valid), 0);
        @(negedge sysclk);                     // N102
        check("c_valid_after_1st", 32'(bus_a.result_valid), 1);
        check("c_busy", 32'(bus_a.busy), 1);
        repeat (48) @(negedge sysclk);         // N150
        bus_a.result_ack = 1;
        @(negedge sysclk);                     // N151
        bus_a.result_ack = 0;
        check("c_mid_ack", 32'(bus_a.result_valid), 0);
        repeat (51) @(negedge sysclk);         // N202
        bus_a.result_ack = 1;
        @(negedge sysclk);                     // N203
        bus_a.result_ack = 0;
        check("c_latch_wins", 32'(bus_a.result_valid), 1);
        repeat (47) @(negedge sysclk);         // N250
        bus_a.result_ack = 1;
        @(negedge sysclk);                     // N251
        bus_a.result_ack = 0;
        repeat (52) @(negedge sysclk);         // N303
        check("c_valid_before_3rd", 32'(bus_a.result_valid), 0);
        @(negedge sysclk);                     // N304
        check("c_valid_after_3rd", 32'(bus_a.result_valid), 1);
        check("c_result_range", 32'(bus_a.result >= 9 && bus_a.result <= 11), 1);
        check("c_busy_still", 32'(bus_a.busy), 1);

        // Reset mid-gate takes effect before the next clock edge
        repeat (30) @(negedge sysclk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus_a.busy), 0);
        check("mid_rst_valid", 32'(bus_a.result_valid), 0);
        check("mid_rst_result", 32'(bus_a.result), 0);
        bus_a.continuous = 0;
        @(negedge sysclk);
        rst_n = 1'b1;
        repeat (2) @(negedge sysclk);
        check("post_rst_busy", 32'(bus_a.busy), 0);

        // Saturation on the 4-bit instance, gate_sel 10
        per_b = 2;
        repeat (5) @(negedge sysclk);
        bus_b.start = 1;
        @(negedge sysclk);
        bus_b.start = 0;
        count_busy_b(n);
`ifdef FREQ_AUTORANGE_EN
        check("s_busy_cycles", 32'(n), 1102);
        check("s_gate_used", 32'(bus_b.gate_used), 3);
`else
        check("s_busy_cycles", 32'(n), 1001);
        check("s_gate_used", 32'(bus_b.gate_used), 2);
`endif
        check("s_result", 32'(bus_b.result), 15);
        check("s_ovf", 32'(bus_b.overflow), 1);
        check("s_valid", 32'(bus_b.result_valid), 1);
        bus_b.result_ack = 1;
        @(negedge sysclk);
        bus_b.result_ack = 0;
        check("s_ack_valid", 32'(bus_b.result_valid), 0);

        // Saturation at the shortest gate latches with overflow in both builds
        bus_b.gate_sel = 2'b11;
        bus_b.start = 1;
        @(negedge sysclk);
        bus_b.start = 0;
        count_busy_b(n);
        check("s3_busy_cycles", 32'(n), 101);
        check("s3_result", 32'(bus_b.result), 15);
        check("s3_ovf", 32'(bus_b.overflow), 1);
        check("s3_gate_used", 32'(bus_b.gate_used), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
